// File: rtl/cacheline_adapter_if.sv
// Cache-line adapter bundle: controller command side plus single-word memory side.
// slave = the adapter itself; master = controller and memory driving it.
interface cacheline_adapter_if #(
   parameter int WORDS_PER_LINE = 8,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32
) ();
   logic                               cl_read;
   logic                               cl_write;
   logic [ADDR_WIDTH-1:0]              cl_addr;
   logic [WORDS_PER_LINE*DATA_WIDTH-1:0] wb_line;
   logic                               cl_busy;
   logic [WORDS_PER_LINE*DATA_WIDTH-1:0] refill_line;
   logic                               mem_req;
   logic                               mem_we;
   logic [ADDR_WIDTH-1:0]              mem_addr;
   logic [DATA_WIDTH-1:0]              mem_wdata;
   logic [DATA_WIDTH-1:0]              mem_rdata;
   logic                               mem_ack;

   modport slave (
      input  cl_read, cl_write, cl_addr, wb_line, mem_rdata, mem_ack,
      output cl_busy, refill_line, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cl_read, cl_write, cl_addr, wb_line, mem_rdata, mem_ack,
      input  cl_busy, refill_line, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cacheline_adapter.sv
// Whole-line transfer engine between cache controller and single-word memory.
// Optional macro CL_CRITICAL_WORD_FIRST_EN: line fills start at the requested word.
module cacheline_adapter #(
   parameter int WORDS_PER_LINE = 8,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32
) (
   input logic                 CLK,
   input logic                 RST,
   cacheline_adapter_if.slave  bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IW    = $clog2(WORDS_PER_LINE);
   localparam int BW    = $clog2(BYTES);
   localparam int OFFW  = IW + BW;
   localparam int LW    = WORDS_PER_LINE * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t                state;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         cnt;
   logic [IW-1:0]         nidx;
   logic [IW-1:0]         start_idx;
   logic                  last;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] line_base;
   logic [LW-1:0]         wline;
   logic [LW-1:0]         refill;
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;

   function automatic logic [ADDR_WIDTH-1:0] word_addr(
      input logic [ADDR_WIDTH-1:0] b,
      input logic [IW-1:0]         i
   );
      return b | (ADDR_WIDTH'(i) << BW);
   endfunction

   assign line_base = bus.cl_addr & ({ADDR_WIDTH{1'b1}} << OFFW);
   assign nidx      = idx + IW'(1);
   assign last      = (cnt == IW'(WORDS_PER_LINE - 1));

`ifdef CL_CRITICAL_WORD_FIRST_EN
   assign start_idx = bus.cl_addr[OFFW-1:BW];
`else
   assign start_idx = '0;
`endif

   assign bus.cl_busy     = (state != IDLE);
   assign bus.refill_line = refill;
   assign bus.mem_req     = req;
   assign bus.mem_we      = we;
   assign bus.mem_addr    = addr;
   assign bus.mem_wdata   = wdata;

   // Transfer FSM: accept a command, then walk the line one acked word at a time.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         idx    <= '0;
         cnt    <= '0;
         base   <= '0;
         wline  <= '0;
         refill <= '0;
         req    <= 1'b0;
         we     <= 1'b0;
         addr   <= '0;
         wdata  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.cl_write) begin
                  state <= WRITE;
                  wline <= bus.wb_line;
                  base  <= line_base;
                  idx   <= '0;
                  cnt   <= '0;
                  req   <= 1'b1;
                  we    <= 1'b1;
                  addr  <= line_base;
                  wdata <= bus.wb_line[DATA_WIDTH-1:0];
               end else if (bus.cl_read) begin
                  state <= READ;
                  base  <= line_base;
                  idx   <= start_idx;
                  cnt   <= '0;
                  req   <= 1'b1;
                  we    <= 1'b0;
                  addr  <= word_addr(line_base, start_idx);
               end
            end
            WRITE: begin
               if (bus.mem_ack) begin
                  if (last) begin
                     state <= IDLE;
                     req   <= 1'b0;
                     we    <= 1'b0;
                  end else begin
                     idx   <= nidx;
                     cnt   <= cnt + IW'(1);
                     addr  <= word_addr(base, nidx);
                     wdata <= wline[int'(nidx)*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
            READ: begin
               if (bus.mem_ack) begin
                  refill[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
                  if (last) begin
                     state <= IDLE;
                     req   <= 1'b0;
                  end else begin
                     idx  <= nidx;
                     cnt  <= cnt + IW'(1);
                     addr <= word_addr(base, nidx);
                  end
               end
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
               we    <= 1'b0;
            end
         endcase
      end
   end
endmodule
